counter_readback: RTL and testbench

//   Read-back path of one 8254 counter, paired with the mode/count-load write path.

---
 rtl/counter_readback_if.sv | 22 ++
 rtl/counter_readback.sv | 90 +++++++++
 tb/tb_counter_readback.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_readback_if.sv
// Bus-side signals of one 8254 counter read-back port.
// The master drives strobes and mode; the slave returns bytes and latch status.
interface counter_readback_if;
  logic       COUNTER_SELECTOR;
  logic       CTRL_WRITE;
  logic       LATCH_CMD;
  logic [1:0] RW_MODE;
  logic       RD_N;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID;
  logic       LATCHED;

  modport master (
    output COUNTER_SELECTOR, CTRL_WRITE, LATCH_CMD, RW_MODE, RD_N,
    input  DATA_OUT, DATA_VALID, LATCHED
  );

  modport slave (
    input  COUNTER_SELECTOR, CTRL_WRITE, LATCH_CMD, RW_MODE, RD_N,
    output DATA_OUT, DATA_VALID, LATCHED
  );
endinterface

// File: rtl/counter_readback.sv
// Read-back path of one 8254 counter: returns the count one byte per read strobe,
// honouring RW_MODE byte order and the Counter Latch snapshot.
module counter_readback #(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned BYTE_WIDTH  = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  counter_readback_if.slave      bus,
  input  logic [COUNT_WIDTH-1:0] CURRENT_COUNT
);

  typedef enum logic [0:0] {StLsb, StMsb} ptr_e;

  ptr_e                   ptr_q;
  logic                   rd_n_q;
  logic [1:0]             rw_mode_q;
  logic [COUNT_WIDTH-1:0] snap_q;
  logic [BYTE_WIDTH-1:0]  shadow_q;

  logic                   ctrl_wr;
  logic                   rd_fall;
  logic [COUNT_WIDTH-1:0] src;
  logic [BYTE_WIDTH-1:0]  rd_byte;
  logic                   rd_release;
  logic                   latched_post;
  logic                   latch_take;

  assign ctrl_wr = bus.CTRL_WRITE & (bus.RW_MODE != 2'b00);
  assign rd_fall = bus.COUNTER_SELECTOR & rd_n_q & ~bus.RD_N;
  assign src     = bus.LATCHED ? snap_q : CURRENT_COUNT;

  always_comb begin
    rd_byte    = src[BYTE_WIDTH-1:0];
    rd_release = 1'b1;
    case (rw_mode_q)
      2'b10:   rd_byte = src[COUNT_WIDTH-1:BYTE_WIDTH];
      2'b11: begin
        if (ptr_q == StMsb) begin
          // Unlatched MSB comes from the shadow so both bytes belong to one count value
          rd_byte = bus.LATCHED ? snap_q[COUNT_WIDTH-1:BYTE_WIDTH] : shadow_q;
        end else begin
          rd_release = 1'b0;
        end
      end
      default: rd_byte = src[BYTE_WIDTH-1:0];
    endcase
    // Latch command is judged against the latch state left by a same-cycle read
    latched_post = bus.LATCHED & ~(rd_fall & rd_release);
    latch_take   = bus.LATCH_CMD & ~latched_post;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr_q          <= StLsb;
      rd_n_q         <= 1'b1;
      rw_mode_q      <= 2'b01;
      snap_q         <= '0;
      shadow_q       <= '0;
      bus.DATA_OUT   <= '0;
      bus.DATA_VALID <= 1'b0;
      bus.LATCHED    <= 1'b0;
    end else begin
      rd_n_q         <= bus.RD_N;
      bus.DATA_VALID <= 1'b0;
      if (ctrl_wr) begin
        rw_mode_q   <= bus.RW_MODE;
        ptr_q       <= StLsb;
        bus.LATCHED <= 1'b0;
      end else begin
        if (rd_fall) begin
          bus.DATA_OUT   <= rd_byte;
          bus.DATA_VALID <= 1'b1;
          if (rw_mode_q == 2'b11) begin
            unique case (ptr_q)
              StLsb: begin
                ptr_q <= StMsb;
                if (!bus.LATCHED) shadow_q <= CURRENT_COUNT[COUNT_WIDTH-1:BYTE_WIDTH];
              end
              StMsb: ptr_q <= StLsb;
            endcase
          end
        end
        if (latch_take) snap_q <= CURRENT_COUNT;
        bus.LATCHED <= latched_post | latch_take;
      end
    end
  end

endmodule

// File: tb/tb_counter_readback.sv
// Directed self-checking bench for counter_readback.
module tb_counter_readback;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] CURRENT_COUNT = 16'h0000;
  int          errors = 0;
  int          checks = 0;

  counter_readback_if bus ();

  counter_readback u_dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .bus           (bus),
    .CURRENT_COUNT (CURRENT_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic do_ctrl(input logic [1:0] m);
    @(negedge CLK);
    bus.CTRL_WRITE = 1'b1;
    bus.RW_MODE    = m;
    @(negedge CLK);
    bus.CTRL_WRITE = 1'b0;
  endtask

  task automatic do_latch();
    @(negedge CLK);
    bus.LATCH_CMD = 1'b1;
    @(negedge CLK);
    bus.LATCH_CMD = 1'b0;
  endtask

  // One RD_N pulse, optionally with LATCH_CMD / CTRL_WRITE in the same cycle.
  task automatic do_read(input logic lat, input logic cw, input logic [1:0] cwm,
                         output logic [7:0] d, output logic v, output logic v2,
                         output logic l);
    @(negedge CLK);
    bus.RD_N       = 1'b0;
    bus.LATCH_CMD  = lat;
    bus.CTRL_WRITE = cw;
    bus.RW_MODE    = cwm;
    @(posedge CLK);
    #1;
    d = bus.DATA_OUT;
    v = bus.DATA_VALID;
    l = bus.LATCHED;
    @(negedge CLK);
    bus.RD_N       = 1'b1;
    bus.LATCH_CMD  = 1'b0;
    bus.CTRL_WRITE = 1'b0;
    @(posedge CLK);
    #1;
    v2 = bus.DATA_VALID;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (bus.DATA_OUT !== 8'h00) begin errors++;
      $display("FAIL reset_data got=%h want=00", bus.DATA_OUT); end
    checks++; if (bus.DATA_VALID !== 1'b0) begin errors++;
      $display("FAIL reset_valid got=%b want=0", bus.DATA_VALID); end
    checks++; if (bus.LATCHED !== 1'b0) begin errors++;
      $display("FAIL reset_latched got=%b want=0", bus.LATCHED); end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_two_byte();
    logic [7:0] d; logic v, v2, l;
    do_ctrl(2'b11);
    CURRENT_COUNT = 16'h1234;
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'h34 || v !== 1'b1 || v2 !== 1'b0) begin errors++;
      $display("FAIL two_byte_lsb got=%h v=%b v2=%b want=34 v=1 v2=0", d, v, v2); end
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'h12 || v !== 1'b1 || v2 !== 1'b0) begin errors++;
      $display("FAIL two_byte_msb got=%h v=%b v2=%b want=12 v=1 v2=0", d, v, v2); end
  endtask

  task automatic test_latch();
    logic [7:0] d; logic v, v2, l;
    do_ctrl(2'b11);
    CURRENT_COUNT = 16'hABCD;
    do_latch();
    checks++; if (bus.LATCHED !== 1'b1) begin errors++;
      $display("FAIL latch_set got=%b want=1", bus.LATCHED); end
    CURRENT_COUNT = 16'h0005;
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'hCD || l !== 1'b1) begin errors++;
      $display("FAIL latch_lsb got=%h l=%b want=CD l=1", d, l); end
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'hAB || l !== 1'b0) begin errors++;
      $display("FAIL latch_msb got=%h l=%b want=AB l=0", d, l); end
  endtask

  task automatic test_latch_ignored();
    logic [7:0] d; logic v, v2, l;
    do_ctrl(2'b01);
    CURRENT_COUNT = 16'h00FF;
    do_latch();
    CURRENT_COUNT = 16'h7777;
    do_latch();
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'hFF || l !== 1'b0) begin errors++;
      $display("FAIL latch_ignored got=%h l=%b want=FF l=0", d, l); end
  endtask

  task automatic test_hold_low();
    int pulses = 0;
    do_ctrl(2'b01);
    CURRENT_COUNT = 16'h0042;
    @(negedge CLK);
    bus.RD_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      if (bus.DATA_VALID === 1'b1) pulses++;
    end
    @(negedge CLK);
    bus.RD_N = 1'b1;
    checks++; if (pulses != 1 || bus.DATA_OUT !== 8'h42) begin errors++;
      $display("FAIL hold_low pulses=%0d data=%h want pulses=1 data=42", pulses, bus.DATA_OUT); end
  endtask

  task automatic test_shadow();
    logic [7:0] d; logic v, v2, l;
    do_ctrl(2'b11);
    CURRENT_COUNT = 16'h01FF;
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'hFF) begin errors++;
      $display("FAIL shadow_lsb got=%h want=FF", d); end
    CURRENT_COUNT = 16'h0200;
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'h01) begin errors++;
      $display("FAIL shadow_msb got=%h want=01", d); end
  endtask

  task automatic test_ctrl_resets_ptr();
    logic [7:0] d; logic v, v2, l;
    do_ctrl(2'b11);
    CURRENT_COUNT = 16'h1111;
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    do_ctrl(2'b10);
    CURRENT_COUNT = 16'h5A3C;
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'h5A) begin errors++;
      $display("FAIL ctrl_ptr_first got=%h want=5A", d); end
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'h5A) begin errors++;
      $display("FAIL ctrl_ptr_second got=%h want=5A", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic v, v2, l;
    do_ctrl(2'b11);
    CURRENT_COUNT = 16'hBEEF;
    do_latch();
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'hEF) begin errors++;
      $display("FAIL reset_mid_lsb got=%h want=EF", d); end
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checks++; if (bus.LATCHED !== 1'b0 || bus.DATA_OUT !== 8'h00) begin errors++;
      $display("FAIL reset_mid_async l=%b data=%h want l=0 data=00", bus.LATCHED, bus.DATA_OUT); end
    @(negedge CLK);
    RESET = 1'b1;
    CURRENT_COUNT = 16'h1357;
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'h57 || v !== 1'b1) begin errors++;
      $display("FAIL reset_mid_after got=%h v=%b want=57 v=1", d, v); end
  endtask

  task automatic test_selector();
    logic [7:0] d; logic v, v2, l;
    do_ctrl(2'b01);
    CURRENT_COUNT = 16'h2222;
    do_latch();
    CURRENT_COUNT = 16'h3333;
    bus.COUNTER_SELECTOR = 1'b0;
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (v !== 1'b0 || l !== 1'b1 || d !== 8'h57) begin errors++;
      $display("FAIL selector_off v=%b l=%b data=%h want v=0 l=1 data=57", v, l, d); end
    bus.COUNTER_SELECTOR = 1'b1;
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'h22 || l !== 1'b0) begin errors++;
      $display("FAIL selector_on got=%h l=%b want=22 l=0", d, l); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic v, v2, l;
    do_ctrl(2'b01);
    CURRENT_COUNT = 16'h3344;
    do_latch();
    CURRENT_COUNT = 16'h5566;
    do_read(1'b1, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'h44 || l !== 1'b1) begin errors++;
      $display("FAIL relatch_read got=%h l=%b want=44 l=1", d, l); end
    CURRENT_COUNT = 16'h7788;
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'h66 || l !== 1'b0) begin errors++;
      $display("FAIL relatch_snap got=%h l=%b want=66 l=0", d, l); end
    // CTRL_WRITE wins over a simultaneous read
    do_ctrl(2'b11);
    CURRENT_COUNT = 16'h9988;
    do_latch();
    do_read(1'b0, 1'b1, 2'b01, d, v, v2, l);
    checks++; if (v !== 1'b0 || l !== 1'b0 || d !== 8'h66) begin errors++;
      $display("FAIL ctrl_override v=%b l=%b data=%h want v=0 l=0 data=66", v, l, d); end
    CURRENT_COUNT = 16'hC3A5;
    do_read(1'b0, 1'b0, 2'b00, d, v, v2, l);
    checks++; if (d !== 8'hA5) begin errors++;
      $display("FAIL ctrl_override_mode got=%h want=A5", d); end
  endtask

  initial begin
    bus.COUNTER_SELECTOR = 1'b1;
    bus.CTRL_WRITE       = 1'b0;
    bus.LATCH_CMD        = 1'b0;
    bus.RW_MODE          = 2'b00;
    bus.RD_N             = 1'b1;
    test_reset();
    test_two_byte();
    test_latch();
    test_latch_ignored();
    test_hold_low();
    test_shadow();
    test_ctrl_resets_ptr();
    test_reset_mid();
    test_selector();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
